mode_sequencer: RTL

Top-level game controller that shares the 16-LED bar and 4-digit 7-segment display between NUM_MODES game-mode blocks. It debounces the front-panel buttons and runs the mode-select menu. It activates exactly one mode block per round and muxes that block's display outputs. It also detects round completion or timeout and keeps a win counter.

---
 rtl/mode_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mode_sequencer                                                           |
// | Game controller: button debounce, mode menu, round sequencing and the    |
// | shared LED / 7-segment mux. ROUND_TIMEOUT_EN builds the round timer.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mode_sequencer #(
    parameter int NUM_MODES       = 3,
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_S       = 60,
    parameter int HOLD_S          = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    btn_mode,
    input  logic                    btn_go_stop,
    input  logic                    btn_back,
    input  logic [NUM_MODES-1:0]    mode_done,
    input  logic [16*NUM_MODES-1:0] mode_led,
    input  logic [20*NUM_MODES-1:0] mode_seg,
    output logic [NUM_MODES-1:0]    active,
    output logic                    btn_go_stop_out,
    output logic [15:0]             led,
    output logic [19:0]             seg_data,
    output logic [7:0]              win_count,
    output logic [1:0]              state_out
);

    localparam int c_SEL_W   = $clog2(NUM_MODES);
    localparam int c_PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_SEC_MAX = (TIMEOUT_S > HOLD_S) ? TIMEOUT_S : HOLD_S;
    localparam int c_SEC_W   = $clog2(c_SEC_MAX + 1);

    localparam logic [c_DB_W-1:0]    c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_PRE_W-1:0]   c_PRE_LAST  = c_PRE_W'(CLK_HZ - 1);
    localparam logic [c_SEC_W-1:0]   c_SEC_SAT   = c_SEC_W'(c_SEC_MAX);
    localparam logic [c_SEC_W-1:0]   c_HOLD_LAST = c_SEC_W'(HOLD_S - 1);
    localparam logic [c_SEL_W-1:0]   c_SEL_LAST  = c_SEL_W'(NUM_MODES - 1);
    localparam logic [NUM_MODES-1:0] c_ONE       = NUM_MODES'(1);
    localparam logic [4:0] c_DIG_P = 5'd16, c_DIG_O = 5'd17, c_DIG_N = 5'd20, c_DIG_BLANK = 5'd31;

    typedef enum logic [1:0] {
        ST_MENU   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [c_SEL_W-1:0]   r_sel, w_sel_next;
    logic [c_PRE_W-1:0]   r_presc;
    logic [c_SEC_W-1:0]   r_sec;
    logic                 r_timed_out, r_arm;
    logic [15:0]          r_led;
    logic [19:0]          r_seg;
    logic [7:0]           r_win_count;
    logic                 w_tick, w_hold_done, w_win, w_to, w_to_next;
    logic [2:0]           w_btn_raw, w_deb, w_press;
    logic [15:0]          w_led_arr [NUM_MODES];
    logic [19:0]          w_seg_arr [NUM_MODES];

    // Button index 0 = mode, 1 = go/stop, 2 = back
    assign w_btn_raw = {btn_back, btn_go_stop, btn_mode};

    generate
        for (genvar b = 0; b < 3; b++) begin : g_btn
            logic              r_s1, r_s2, r_lvl, r_lvl_q;
            logic [c_DB_W-1:0] r_cnt;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_lvl_q <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_btn_raw[b];
                    r_s2    <= r_s1;
                    r_lvl_q <= r_lvl;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
            assign w_deb[b]   = r_lvl;
            assign w_press[b] = r_lvl & ~r_lvl_q;
        end

        for (genvar k = 0; k < NUM_MODES; k++) begin : g_mux
            assign w_led_arr[k] = mode_led[16*k +: 16];
            assign w_seg_arr[k] = mode_seg[20*k +: 20];
        end
    endgenerate

    assign w_tick      = (r_presc == c_PRE_LAST);
    assign w_hold_done = w_tick && (r_sec == c_HOLD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_win        = 1'b0;
        w_to         = 1'b0;
        case (r_state)
            ST_MENU: begin
                if (w_press[0])
                    w_sel_next = (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
                if (w_press[1])
                    w_state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (mode_done[r_sel]) begin
                    w_state_next = ST_RESULT;
                    w_win        = 1'b1;
                end else if (w_press[2]) begin
                    w_state_next = ST_MENU;
`ifdef ROUND_TIMEOUT_EN
                end else if (w_tick && (r_sec == c_SEC_W'(TIMEOUT_S - 1))) begin
                    w_state_next = ST_RESULT;
                    w_to         = 1'b1;
`endif
                end
            end
            ST_RESULT: begin
                if (w_press[1] || w_press[2] || w_hold_done)
                    w_state_next = ST_MENU;
            end
            default: w_state_next = ST_MENU;
        endcase
    end

    assign w_to_next = (w_state_next != r_state) ? w_to : r_timed_out;

    // Prescaler and second counter restart on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_sec   <= '0;
        end else if (w_state_next != r_state) begin
            r_presc <= '0;
            r_sec   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            if (r_sec != c_SEC_SAT)
                r_sec <= r_sec + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_MENU;
            r_sel       <= '0;
            r_timed_out <= 1'b0;
            r_arm       <= 1'b0;
            r_led       <= '0;
            r_seg       <= 20'hFFFFF;
            r_win_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sel       <= w_sel_next;
            r_timed_out <= w_to_next;
            // Arms only once go has been seen released inside this round
            r_arm       <= (r_state == ST_PLAY) && (w_state_next == ST_PLAY) && (r_arm || !w_deb[1]);
            if (w_win && (r_win_count != 8'hFF))
                r_win_count <= r_win_count + 8'd1;
            if (w_state_next == ST_MENU) begin
                r_led <= 16'h8000 >> w_sel_next;
                r_seg <= {c_DIG_P, c_DIG_BLANK, c_DIG_BLANK, 5'(w_sel_next) + 5'd1};
            end else if (w_state_next == ST_RESULT && w_to_next) begin
                r_led <= '0;
                r_seg <= {c_DIG_N, c_DIG_O, c_DIG_BLANK, c_DIG_BLANK};
            end else begin
                r_led <= w_led_arr[w_sel_next];
                r_seg <= w_seg_arr[w_sel_next];
            end
        end
    end

    always_comb begin
        active = '0;
        if (r_state == ST_PLAY || (r_state == ST_RESULT && !r_timed_out))
            active = c_ONE << r_sel;
    end

    assign btn_go_stop_out = (r_state == ST_PLAY) && r_arm && w_deb[1];
    assign led             = r_led;
    assign seg_data        = r_seg;
    assign win_count       = r_win_count;
    assign state_out       = r_state;

endmodule
`default_nettype wire
